// File: rtl/fifo_serializer.sv
// Drain stage for a show-ahead FIFO: pops one IN_WIDTH entry and emits it as
// RATIO narrower valid/ready beats, LSB slice first, with the final beat tagged.
module fifo_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_en,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_value,
  output logic                 fifo_dequeue_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = $clog2(RATIO);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  state_e              state_q;
  logic [IN_WIDTH-1:0] sreg_q;
  logic [IN_WIDTH-1:0] sreg_d;
  logic [BW-1:0]       beat_q;
  logic [BW-1:0]       beat_d;
  logic                holding;
  logic                last_beat;
  logic                transfer;
  logic                can_load;

  assign holding   = (state_q == ST_HOLD);
  assign last_beat = holding && (beat_q == BW'(RATIO - 1));
  assign transfer  = holding && out_ready;

  // Reloading on the accepted last beat is what gives zero-bubble entry turnover.
  assign can_load        = !holding || (transfer && last_beat);
  assign fifo_dequeue_en = can_load && !fifo_empty && !flush_en && !reset;

  assign out_valid = holding;
  assign busy      = holding;
  assign out_data  = sreg_q[OUT_WIDTH-1:0];
  assign out_last  = last_beat;

  always_comb begin
    sreg_d = sreg_q >> OUT_WIDTH;
    beat_d = beat_q + BW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      beat_q  <= '0;
    end else if (flush_en) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else if (fifo_dequeue_en) begin
      state_q <= ST_HOLD;
      sreg_q  <= fifo_value;
      beat_q  <= '0;
    end else if (transfer) begin
      if (last_beat) begin
        state_q <= ST_IDLE;
        beat_q  <= '0;
      end else begin
        sreg_q <= sreg_d;
        beat_q <= beat_d;
      end
    end
  end

  a_no_deq_when_empty: assert property (@(posedge clk) disable iff (reset)
    !(fifo_dequeue_en && fifo_empty));

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer: a queue stands in for the show-ahead FIFO,
// accepted beats and dequeue cycles are logged and compared against constants.
module tb_fifo_serializer;

  localparam int IW = 64;
  localparam int OW = 16;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    int            c;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_en;
  logic          fifo_empty;
  logic [IW-1:0] fifo_value;
  logic          fifo_dequeue_en;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [IW-1:0] q[$];
  beat_t         bq[$];
  int            dq[$];
  int            ntick;
  int            n_tests;
  int            n_fail;

  localparam logic [IW-1:0] E1 = 64'h4444_3333_2222_1111;
  localparam logic [IW-1:0] E2 = 64'h8888_7777_6666_5555;
  localparam logic [IW-1:0] E3 = 64'hDDDD_CCCC_BBBB_AAAA;
  localparam logic [IW-1:0] G  = 64'hABCD_0123_4567_89EF;

  fifo_serializer #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_en       (flush_en),
    .fifo_empty     (fifo_empty),
    .fifo_value     (fifo_value),
    .fifo_dequeue_en(fifo_dequeue_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_value = (q.size() == 0) ? '0 : q[0];
  endtask

  task automatic push(input logic [IW-1:0] v);
    q.push_back(v);
    refresh();
  endtask

  // One clock: log beat/dequeue seen before the edge, then update the FIFO model.
  task automatic tick();
    logic d;
    logic f;
    #1;
    d = fifo_dequeue_en;
    f = flush_en;
    if (out_valid && out_ready && !f && !reset) bq.push_back('{out_data, out_last, ntick});
    if (d) dq.push_back(ntick);
    @(posedge clk);
    #1;
    ntick++;
    if (f) q.delete();
    else if (d) void'(q.pop_front());
    refresh();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OW-1:0] e1s[4];
    logic [OW-1:0] e2s[4];
    logic [OW-1:0] gs[4];
    e1s = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    e2s = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    gs  = '{16'h89EF, 16'h4567, 16'h0123, 16'hABCD};
    n_tests = 0;
    n_fail  = 0;
    ntick   = 0;

    // Reset state, with a non-empty FIFO so the dequeue gating is exercised.
    reset     = 1'b1;
    flush_en  = 1'b0;
    out_ready = 1'b0;
    refresh();
    push(E1);
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_deq", fifo_dequeue_en, 0);
    q.delete();
    refresh();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    tick();

    // Basic serialize
    out_ready = 1'b1;
    bq.delete();
    dq.delete();
    push(E1);
    #1;
    check("t1_deq_lat", fifo_dequeue_en, 1);
    repeat (6) tick();
    check("t1_nbeats", bq.size(), 4);
    check("t1_ndeq", dq.size(), 1);
    for (int i = 0; i < bq.size() && i < 4; i++) begin
      check($sformatf("t1_data%0d", i), bq[i].d, e1s[i]);
      check($sformatf("t1_last%0d", i), bq[i].l, (i == 3) ? 1 : 0);
      check($sformatf("t1_cyc%0d", i), bq[i].c, bq[0].c + i);
    end
    if (bq.size() > 0 && dq.size() > 0) check("t1_first_lat", bq[0].c, dq[0] + 1);
    check("t1_idle", busy, 0);

    // Back-to-back: three entries
    bq.delete();
    dq.delete();
    push(64'h0004_0003_0002_0001);
    push(64'h0008_0007_0006_0005);
    push(64'h000C_000B_000A_0009);
    repeat (14) tick();
    check("t2_nbeats", bq.size(), 12);
    check("t2_ndeq", dq.size(), 3);
    for (int i = 0; i < bq.size() && i < 12; i++) begin
      check($sformatf("t2_data%0d", i), bq[i].d, i + 1);
      check($sformatf("t2_last%0d", i), bq[i].l, (i % 4 == 3) ? 1 : 0);
      check($sformatf("t2_cyc%0d", i), bq[i].c, bq[0].c + i);
    end
    if (dq.size() == 3) begin
      check("t2_deq1", dq[1] - dq[0], 4);
      check("t2_deq2", dq[2] - dq[0], 8);
    end

    // Backpressure on beat 2, with a second entry waiting
    bq.delete();
    dq.delete();
    push(E1);
    push(E2);
    repeat (3) tick();
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_stall_data%0d", i), out_data, 16'h3333);
      check($sformatf("t3_stall_last%0d", i), out_last, 0);
      check($sformatf("t3_stall_deq%0d", i), fifo_dequeue_en, 0);
      tick();
    end
    out_ready = 1'b1;
    repeat (2) tick();
    check("t3_nbeats", bq.size(), 4);
    if (bq.size() == 4) begin
      check("t3_b2", bq[2].d, 16'h3333);
      check("t3_b2_last", bq[2].l, 0);
      check("t3_b3", bq[3].d, 16'h4444);
      check("t3_b3_last", bq[3].l, 1);
      check("t3_b3_cyc", bq[3].c, bq[2].c + 1);
    end
    check("t3_ndeq", dq.size(), 2);
    repeat (4) tick();
    check("t3_e2_nbeats", bq.size(), 8);
    for (int i = 4; i < bq.size() && i < 8; i++) begin
      check($sformatf("t3_e2_data%0d", i - 4), bq[i].d, e2s[i - 4]);
      check($sformatf("t3_e2_last%0d", i - 4), bq[i].l, (i == 7) ? 1 : 0);
    end

    // Empty boundary: last beat just accepted and FIFO empty
    check("t4_valid_drop", out_valid, 0);
    check("t4_no_deq", fifo_dequeue_en, 0);
    bq.delete();
    dq.delete();
    repeat (2) tick();
    check("t4_idle_beats", bq.size(), 0);
    check("t4_idle_deq", dq.size(), 0);
    push(E3);
    repeat (6) tick();
    check("t4_nbeats", bq.size(), 4);
    check("t4_ndeq", dq.size(), 1);
    if (bq.size() > 0 && dq.size() > 0) begin
      check("t4_first_lat", bq[0].c, dq[0] + 1);
      check("t4_first_data", bq[0].d, 16'hAAAA);
    end

    // Flush during beat 1 with two entries still queued
    bq.delete();
    dq.delete();
    push(64'h0F03_0F02_0F01_0F00);
    push(64'h1F03_1F02_1F01_1F00);
    push(64'h2F03_2F02_2F01_2F00);
    repeat (2) tick();
    check("t5_beat1", out_data, 16'h0F01);
    flush_en = 1'b1;
    #1;
    check("t5_flush_nodeq", fifo_dequeue_en, 0);
    tick();
    flush_en = 1'b0;
    check("t5_post_valid", out_valid, 0);
    check("t5_post_last", out_last, 0);
    check("t5_post_busy", busy, 0);
    repeat (3) tick();
    check("t5_nbeats", bq.size(), 1);
    check("t5_ndeq", dq.size(), 1);
    bq.delete();
    push(G);
    repeat (6) tick();
    check("t5_fresh_nbeats", bq.size(), 4);
    for (int i = 0; i < bq.size() && i < 4; i++) begin
      check($sformatf("t5_fresh_data%0d", i), bq[i].d, gs[i]);
      check($sformatf("t5_fresh_last%0d", i), bq[i].l, (i == 3) ? 1 : 0);
    end

    // Async reset between edges during beat 2, next entry waiting
    bq.delete();
    dq.delete();
    push(E1);
    repeat (3) tick();
    check("t6_beat2", out_data, 16'h3333);
    push(E2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_last", out_last, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_deq", fifo_dequeue_en, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_post_idle", out_valid, 0);
    check("t6_post_deq", fifo_dequeue_en, 1);
    bq.delete();
    dq.delete();
    repeat (5) tick();
    check("t6_nbeats", bq.size(), 4);
    for (int i = 0; i < bq.size() && i < 4; i++) begin
      check($sformatf("t6_data%0d", i), bq[i].d, e2s[i]);
      check($sformatf("t6_last%0d", i), bq[i].l, (i == 3) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
